// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: default widths, opcode map,
// FSM state type and opcode-class helpers.
package calc_pkg;

  localparam int CALC_WIDTH = 16;
  localparam int CALC_OPW   = 4;

  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_NOT = 1;
  localparam int unsigned OP_SHL = 2;
  localparam int unsigned OP_SHR = 3;
  localparam int unsigned OP_INC = 4;
  localparam int unsigned OP_AND = 5;
  localparam int unsigned OP_OR  = 6;
  localparam int unsigned OP_XOR = 7;
  localparam int unsigned OP_ADD = 8;
  localparam int unsigned OP_SUB = 9;
  localparam int unsigned OP_MUL = 10;
  localparam int unsigned OP_MAX = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_EXEC,
    ST_DONE
  } state_e;

  function automatic logic is_unary(input int unsigned op);
    return (op >= OP_NOT) && (op <= OP_INC);
  endfunction

  function automatic logic is_binary(input int unsigned op);
    return (op >= OP_AND) && (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/calc_seq.sv
// Operation sequencer driving the combinational calculator ALU.
// Optional build macro CALC_CHAIN_EN: reuse the last accepted result as operand A.
module calc_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int OPW   = CALC_OPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic             chain,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [OPW-1:0]   alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             res_err_q, res_err_d;
  logic             op_unary, op_binary, sel_binary;

  assign op_unary   = is_unary(32'(op));
  assign op_binary  = is_binary(32'(op));
  assign sel_binary = is_binary(32'(alu_sel_q));

`ifdef CALC_CHAIN_EN
  logic [WIDTH-1:0] last_q, last_d;

  // Only results the consumer actually took become the chain operand.
  always_comb begin
    last_d = last_q;
    if (res_valid_q && res_ready) begin
      last_d = res_data_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_chain;
  assign unused_chain = chain;
`endif

  always_comb begin
    state_d     = state_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          alu_sel_d = op;
          if (op_unary || op_binary) begin
            state_d = ST_LOAD_A;
`ifdef CALC_CHAIN_EN
            if (chain) begin
              alu_a_d = last_q;
              state_d = op_binary ? ST_LOAD_B : ST_EXEC;
            end
`endif
          end else begin
            // NOP and invalid opcodes finish immediately with a zero result.
            state_d     = ST_DONE;
            res_data_d  = '0;
            res_valid_d = 1'b1;
            res_err_d   = (32'(op) > OP_MAX);
          end
        end
      end
      ST_LOAD_A: begin
        if (in_valid) begin
          alu_a_d = in_data;
          state_d = sel_binary ? ST_LOAD_B : ST_EXEC;
        end
      end
      ST_LOAD_B: begin
        if (in_valid) begin
          alu_b_d = in_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_data_d  = alu_y;
        res_valid_d = 1'b1;
        res_err_d   = 1'b0;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      alu_sel_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign busy      = (state_q != ST_IDLE);
  assign alu_sel   = alu_sel_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_calc_seq.sv
// Scoreboard bench for calc_seq with a behavioural ALU beside it; honours CALC_CHAIN_EN.
module tb_calc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic        chain;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  alu_sel;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_y;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;
  logic        busy;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  calc_seq #(.WIDTH(16), .OPW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .chain(chain),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_y = 16'h0000;
    case (alu_sel)
      4'd1:  alu_y = ~alu_a;
      4'd2:  alu_y = alu_a << 1;
      4'd3:  alu_y = alu_a >> 1;
      4'd4:  alu_y = alu_a + 16'd1;
      4'd5:  alu_y = alu_a & alu_b;
      4'd6:  alu_y = alu_a | alu_b;
      4'd7:  alu_y = alu_a ^ alu_b;
      4'd8:  alu_y = alu_a + alu_b;
      4'd9:  alu_y = alu_a - alu_b;
      4'd10: alu_y = alu_a * alu_b;
      default: alu_y = 16'h0000;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake pops one expected entry.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 32'(res_data), 32'hDEAD);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("result: sel=%0d a=0x%04h b=0x%04h -> data=0x%04h err=%0b (exp 0x%04h err=%0b)",
                 alu_sel, alu_a, alu_b, res_data, res_err, e.data, e.err);
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_err", 32'(res_err), 32'(e.err));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, offer up to two operands, hold the result for 'stall' cycles.
  task automatic run_op(input logic [3:0] o, input logic ch, input logic [15:0] a,
                        input logic [15:0] b, input int exp_used, input int gap,
                        input int stall, input logic extra, input logic [15:0] exp_data,
                        input logic exp_err, input int lat);
    int cyc, fed, wait_cnt;
    logic hs, busy_ok, stable_ok;
    logic [15:0] held;
    exp_t e;
    e.err = exp_err;
    e.data = exp_data;
    sb_q.push_back(e);
    res_ready = (stall == 0);
    start = 1'b1; op = o; chain = ch; in_valid = 1'b0;
    tick;
    start = 1'b0; chain = 1'b0;
    cyc = 1; fed = 0; wait_cnt = gap; busy_ok = 1'b1;
    while (!res_valid && cyc < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      in_valid = (fed < 2) && (wait_cnt == 0);
      in_data  = (fed == 0) ? a : b;
      start    = extra && (cyc % 2 == 1);
      op       = extra ? 4'd13 : o;
      hs = in_valid && in_ready;
      tick;
      cyc++;
      if (hs) begin
        fed++;
        wait_cnt = gap;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("res_valid_seen", 32'(res_valid), 32'd1);
    check("operands_used", 32'(fed), 32'(exp_used));
    if (lat > 0) check("latency", 32'(cyc), 32'(lat));
    held = res_data;
    stable_ok = 1'b1;
    for (int k = 0; k < stall; k++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      start = extra && (k % 2 == 0);
      tick;
      if (res_valid !== 1'b1 || res_data !== held) stable_ok = 1'b0;
    end
    start = 1'b0;
    check("busy_during_op", 32'(busy_ok), 32'd1);
    if (stall > 0) check("res_held_under_stall", 32'(stable_ok), 32'd1);
    res_ready = 1'b1;
    tick;
    check("res_valid_cleared", 32'(res_valid), 32'd0);
    check("idle_after_accept", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; chain = 1'b0;
    in_valid = 1'b0; in_data = 16'h0; res_ready = 1'b1;
    tick; tick;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_alu_regs", {alu_sel, 12'h0, alu_a}, 32'd0);
    reset = 1'b0;
    tick;

    run_op(4'd8, 1'b0, 16'h1234, 16'h0001, 2, 0, 0, 1'b0, 16'h1235, 1'b0, 4);
    check("alu_a_add", 32'(alu_a), 32'h1234);
    check("alu_b_add", 32'(alu_b), 32'h0001);
    run_op(4'd10, 1'b0, 16'h0100, 16'h0100, 2, 0, 0, 1'b0, 16'h0000, 1'b0, 4);
    run_op(4'd9, 1'b0, 16'h0000, 16'h0001, 2, 0, 0, 1'b0, 16'hFFFF, 1'b0, 4);
    run_op(4'd3, 1'b0, 16'h8001, 16'h5555, 1, 0, 0, 1'b0, 16'h4000, 1'b0, 3);
    check("unary_keeps_b", 32'(alu_b), 32'h0001);
    run_op(4'd13, 1'b0, 16'h7777, 16'h7777, 0, 0, 0, 1'b0, 16'h0000, 1'b1, 1);
    run_op(4'd0, 1'b0, 16'h7777, 16'h7777, 0, 0, 0, 1'b0, 16'h0000, 1'b0, 1);
    run_op(4'd7, 1'b0, 16'hAAAA, 16'h0F0F, 2, 3, 5, 1'b1, 16'hA5A5, 1'b0, 0);

    // Abort in LOAD_B: partial operand must be discarded.
    start = 1'b1; op = 4'd8;
    tick;
    start = 1'b0; in_valid = 1'b1; in_data = 16'hAAAA;
    tick;
    in_valid = 1'b0;
    check("in_load_b", 32'(in_ready), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    check("abort_alu_sel", 32'(alu_sel), 32'd0);
    tick;
    reset = 1'b0;
    tick;
    run_op(4'd5, 1'b0, 16'hF0F0, 16'h0FF0, 2, 0, 0, 1'b0, 16'h00F0, 1'b0, 4);

    run_op(4'd8, 1'b0, 16'h0002, 16'h0003, 2, 0, 0, 1'b0, 16'h0005, 1'b0, 4);
`ifdef CALC_CHAIN_EN
    run_op(4'd8, 1'b1, 16'h0004, 16'h0004, 1, 0, 0, 1'b0, 16'h0009, 1'b0, 3);
`else
    run_op(4'd8, 1'b1, 16'h0004, 16'h0004, 2, 0, 0, 1'b0, 16'h0008, 1'b0, 4);
`endif

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
